// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter sharing one combinational ALU
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins a tie; default is round-robin)
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_COMP_WIDTH
`define ALU_COMP_WIDTH 3
`endif
`ifndef ALU_OP_NOP
`define ALU_OP_NOP 4'd0
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd1
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 4'd2
`endif
`ifndef ALU_COMP_EQ
`define ALU_COMP_EQ 0
`endif
`ifndef ALU_COMP_LT
`define ALU_COMP_LT 1
`endif
`ifndef ALU_COMP_LTU
`define ALU_COMP_LTU 2
`endif

module alu_arbiter #(
  parameter int DW  = `DATA_WIDTH,
  parameter int OPW = `ALU_OP_WIDTH,
  parameter int CW  = `ALU_COMP_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_din1,
  input  logic [DW-1:0]  req0_din2,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_din1,
  input  logic [DW-1:0]  req1_din2,
  input  logic [OPW-1:0] req1_op,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic [DW-1:0]  resp0_dout,
  output logic [CW-1:0]  resp0_comp,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [DW-1:0]  resp1_dout,
  output logic [CW-1:0]  resp1_comp,
  output logic [DW-1:0]  alu_din1,
  output logic [DW-1:0]  alu_din2,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_dout,
  input  logic [CW-1:0]  alu_comp
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t        state, state_next;
  logic          owner;
  logic [1:0]    resp_valid;
  logic [DW-1:0] result;
  logic [CW-1:0] comp;
  logic          grant;
  logic          owner_ready;
  logic          handshake;
  logic          free;
  logic          accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic          last_grant;
`endif

  // Pick the winning port: a lone requester wins, ties go by priority policy
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Slot availability, accept handshake, ALU drive and next state
  always_comb begin
    state_next  = state;
    owner_ready = owner ? resp1_ready : resp0_ready;
    handshake   = (state == RESP) && resp_valid[owner] && owner_ready;
    free        = (state == IDLE) || handshake;
    accept      = free && !rst && (grant ? req1_valid : req0_valid);
    req0_ready  = accept && !grant;
    req1_ready  = accept && grant;
    alu_op      = `ALU_OP_NOP;
    alu_din1    = '0;
    alu_din2    = '0;
    if (accept) begin
      alu_op   = grant ? req1_op   : req0_op;
      alu_din1 = grant ? req1_din1 : req0_din1;
      alu_din2 = grant ? req1_din2 : req0_din2;
    end
    if (accept) begin
      state_next = RESP;
    end else if (handshake) begin
      state_next = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Result/flag capture on accept, response valid ownership and priority history
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      resp_valid <= 2'b00;
      result     <= '0;
      comp       <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else if (accept) begin
      result     <= alu_dout;
      comp       <= alu_comp;
      owner      <= grant;
      resp_valid <= grant ? 2'b10 : 2'b01;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= grant;
`endif
    end else if (handshake) begin
      resp_valid <= 2'b00;
    end
  end

  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_dout  = result;
  assign resp1_dout  = result;
  assign resp0_comp  = comp;
  assign resp1_comp  = comp;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter (honours ALU_ARB_FIXED_PRIO_EN)
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_COMP_WIDTH
`define ALU_COMP_WIDTH 3
`endif
`ifndef ALU_OP_NOP
`define ALU_OP_NOP 4'd0
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd1
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 4'd2
`endif
`ifndef ALU_COMP_EQ
`define ALU_COMP_EQ 0
`endif
`ifndef ALU_COMP_LT
`define ALU_COMP_LT 1
`endif
`ifndef ALU_COMP_LTU
`define ALU_COMP_LTU 2
`endif

module tb_alu_arbiter;
  localparam int DW  = `DATA_WIDTH;
  localparam int OPW = `ALU_OP_WIDTH;
  localparam int CW  = `ALU_COMP_WIDTH;
  localparam logic [OPW-1:0] OP_XOR = 4'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]  req0_din1, req0_din2, req1_din1, req1_din2;
  logic [OPW-1:0] req0_op, req1_op;
  logic           resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [DW-1:0]  resp0_dout, resp1_dout;
  logic [CW-1:0]  resp0_comp, resp1_comp;
  logic [DW-1:0]  alu_din1, alu_din2, alu_dout;
  logic [OPW-1:0] alu_op;
  logic [CW-1:0]  alu_comp;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] dout;
    logic [CW-1:0] comp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_g;
  logic exp_g;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_din1(req0_din1), .req0_din2(req0_din2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_din1(req1_din1), .req1_din2(req1_din2), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_dout(resp0_dout), .resp0_comp(resp0_comp),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_dout(resp1_dout), .resp1_comp(resp1_comp),
    .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_op(alu_op),
    .alu_dout(alu_dout), .alu_comp(alu_comp)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: ADD/SUB give no flags, XOR-class ops also report compare flags
  function automatic logic [CW+DW-1:0] alu_fn(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    d = '0;
    c = '0;
    case (op)
      `ALU_OP_NOP: d = '0;
      `ALU_OP_ADD: d = a + b;
      `ALU_OP_SUB: d = a - b;
      default: begin
        d = a ^ b;
        c[`ALU_COMP_EQ]  = (a == b);
        c[`ALU_COMP_LT]  = ($signed(a) < $signed(b));
        c[`ALU_COMP_LTU] = (a < b);
      end
    endcase
    return {c, d};
  endfunction

  assign {alu_comp, alu_dout} = alu_fn(alu_op, alu_din1, alu_din2);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(logic port, logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t e;
    e.port = port;
    {e.comp, e.dout} = alu_fn(op, a, b);
    sb.push_back(e);
  endtask

  task automatic pop_check(string tag, logic port, logic [DW-1:0] dout, logic [CW-1:0] comp);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_port"}, port, e.port);
      chk({tag, "_dout"}, dout, e.dout);
      chk({tag, "_comp"}, comp, e.comp);
    end
  endtask

  // One clock: check readies at negedge, retire responses, record accepts
  task automatic tick(string tag, logic e0, logic e1);
    @(negedge clk);
    chk({tag, "_rdy0"}, req0_ready, e0);
    chk({tag, "_rdy1"}, req1_ready, e1);
    if (resp0_valid && resp0_ready) pop_check({tag, "_r0"}, 1'b0, resp0_dout, resp0_comp);
    if (resp1_valid && resp1_ready) pop_check({tag, "_r1"}, 1'b1, resp1_dout, resp1_comp);
    if (e0) begin
      chk({tag, "_aluop0"}, alu_op, req0_op);
      push(1'b0, req0_op, req0_din1, req0_din2);
    end
    if (e1) begin
      chk({tag, "_aluop1"}, alu_op, req1_op);
      push(1'b1, req1_op, req1_din1, req1_din2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = `ALU_OP_ADD; req0_din1 = 32'd1; req0_din2 = 32'd1;
    req1_valid = 1'b0; req1_op = `ALU_OP_NOP; req1_din1 = '0;   req1_din2 = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(posedge clk); #1;
    tick("rst_a", 1'b0, 1'b0);
    tick("rst_b", 1'b0, 1'b0);
    rst = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("rst_resp0_valid", resp0_valid, 1'b0);
    chk("rst_resp1_valid", resp1_valid, 1'b0);
    chk("rst_dout", resp0_dout, 32'd0);
    chk("rst_comp", resp0_comp, 3'd0);
    last_g = 1'b1;

    // 1: single ADD, response next cycle
    req0_valid = 1'b1; req0_op = `ALU_OP_ADD; req0_din1 = 32'd5; req0_din2 = 32'd7;
    tick("t1_acc", 1'b1, 1'b0);
    last_g = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("t1_resp0_valid", resp0_valid, 1'b1);
    chk("t1_resp1_valid", resp1_valid, 1'b0);
    chk("t1_dout", resp0_dout, 32'd12);
    chk("t1_comp", resp0_comp, 3'd0);
    tick("t1_resp", 1'b0, 1'b0);

    // 6: idle drives NOP
    #1;
    chk("t6_alu_op", alu_op, `ALU_OP_NOP);
    chk("t6_din1", alu_din1, 32'd0);
    chk("t6_din2", alu_din2, 32'd0);
    tick("t6_idle", 1'b0, 1'b0);

    // 2: both ports valid every cycle
    req1_valid = 1'b1; req1_op = `ALU_OP_ADD; req1_din1 = 32'd100; req1_din2 = 32'd3;
    req0_valid = 1'b1; req0_op = OP_XOR;
    for (int i = 0; i < 4; i++) begin
      req0_din1 = 32'(10 + i);
      req0_din2 = 32'd12;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = ~last_g;
`endif
      tick("t2_tie", exp_g == 1'b0, exp_g == 1'b1);
      last_g = exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick("t2_drain", 1'b0, 1'b0);

    // 3: stalled response blocks the other port
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = `ALU_OP_SUB; req1_din1 = 32'd3; req1_din2 = 32'd5;
    tick("t3_acc", 1'b0, 1'b1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = `ALU_OP_ADD; req0_din1 = 32'd20; req0_din2 = 32'd22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_hold_valid", resp1_valid, 1'b1);
      chk("t3_hold_dout", resp1_dout, 32'hFFFF_FFFE);
      chk("t3_hold_aluop", alu_op, `ALU_OP_NOP);
      tick("t3_hold", 1'b0, 1'b0);
    end
    resp1_ready = 1'b1;
    tick("t3_release", 1'b1, 1'b0);
    req0_valid = 1'b0;
    tick("t3_drain", 1'b0, 1'b0);

    // 4: back-to-back stream on port 0
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_op = `ALU_OP_ADD; req0_din1 = 32'(i * 3); req0_din2 = 32'd100;
      #1;
      if (i > 0) chk("t4_valid", resp0_valid, 1'b1);
      tick("t4_stream", 1'b1, 1'b0);
    end
    req0_valid = 1'b0;
    #1;
    chk("t4_last_valid", resp0_valid, 1'b1);
    tick("t4_drain", 1'b0, 1'b0);

    // 5: reset while a response is pending
    req0_valid = 1'b1; req0_op = `ALU_OP_ADD; req0_din1 = 32'd1; req0_din2 = 32'd2;
    tick("t5_acc", 1'b1, 1'b0);
    resp0_ready = 1'b0;
    req0_valid = 1'b0;
    rst = 1'b1;
    req1_valid = 1'b1; req1_op = `ALU_OP_SUB; req1_din1 = 32'd9; req1_din2 = 32'd4;
    tick("t5_rst", 1'b0, 1'b0);
    sb.delete();
    rst = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    #1;
    chk("t5_resp0_valid", resp0_valid, 1'b0);
    chk("t5_resp1_valid", resp1_valid, 1'b0);
    tick("t5_idle", 1'b0, 1'b0);
    req1_valid = 1'b1; req1_op = `ALU_OP_ADD; req1_din1 = 32'd2; req1_din2 = 32'd2;
    tick("t5_post", 1'b0, 1'b1);
    req1_valid = 1'b0;
    tick("t5_drain", 1'b0, 1'b0);

    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
